// File: rtl/shared_cla_sequencer_pkg.sv
// Shared definitions for the shared_cla_sequencer block.
//   state_t : sequencer FSM states (IDLE, RUN, DONE)
//   NIB_W   : width of one digit processed per RUN cycle
//   cnt_w() : width of the nibble counter for a given digit count
package shared_cla_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int NIB_W = 4;

  // A single-digit operand still needs a 1-bit counter to be legal hardware.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/shared_cla_sequencer_if.sv
// Client-side bus of the shared_cla_sequencer.
//   req       : per-client level request (bit i = client i)
//   a_x, b_x  : client operands, sub_x selects a-b instead of a+b
//   gnt       : one-hot acceptance (combinational, capture cycle)
//   busy/done : operation in flight / one-cycle result-valid pulse
//   done_id, sum, c_out, ovf : held result of the most recent operation
// Modports: master = the clients, slave = the sequencer.
interface shared_cla_sequencer_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic [1:0]   req;
  logic [W-1:0] a_0;
  logic [W-1:0] b_0;
  logic         sub_0;
  logic [W-1:0] a_1;
  logic [W-1:0] b_1;
  logic         sub_1;
  logic [1:0]   gnt;
  logic         busy;
  logic         done;
  logic         done_id;
  logic [W-1:0] sum;
  logic         c_out;
  logic         ovf;

  modport master (
    output req, a_0, b_0, sub_0, a_1, b_1, sub_1,
    input  gnt, busy, done, done_id, sum, c_out, ovf
  );

  modport slave (
    input  req, a_0, b_0, sub_0, a_1, b_1, sub_1,
    output gnt, busy, done, done_id, sum, c_out, ovf
  );
endinterface

// File: rtl/shared_cla_sequencer_cla4.sv
// 4-bit carry-lookahead adder, the single arithmetic unit of the sequencer.
//   a_i, b_i : 4-bit addends      c_0_i : carry in
//   s_o      : 4-bit sum          c_4_o : carry out of bit 3
module bit_4_carry_lookahead (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_0_i,
  output logic [3:0] s_o,
  output logic       c_4_o
);
  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a_i & b_i;
  assign p = a_i ^ b_i;

  // Every carry is a flat two-level function of g/p/c0, no rippling.
  assign c[0] = c_0_i;
  assign c[1] = g[0] | (p[0] & c_0_i);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_0_i);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c_0_i);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c_0_i);

  assign s_o   = p ^ c[3:0];
  assign c_4_o = c[4];
endmodule

// File: rtl/shared_cla_sequencer.sv
// Two-client add/subtract sequencer sharing one 4-bit CLA adder.
// A round-robin arbiter accepts one client in IDLE, the operands are then
// processed one nibble per cycle (LSB first) for NIBBLES cycles, and the
// result is presented with a one-cycle done pulse and held until the next.
//   clk    : rising-edge clock
//   rst_n  : synchronous active-low reset
//   bus_if : client bus (slave side), see shared_cla_sequencer_if
module shared_cla_sequencer
  import shared_cla_sequencer_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  shared_cla_sequencer_if.slave   bus_if
);
  localparam int W  = NIB_W * NIBBLES;
  localparam int CW = cnt_w(NIBBLES);
  localparam logic [CW-1:0] LAST_NIB = CW'(NIBBLES - 1);

  state_t        state_q;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [W-1:0]  res_q;
  logic [W-1:0]  res_d;
  logic          carry_q;
  logic [CW-1:0] nib_q;
  logic          id_q;
  logic          last_q;
  logic          busy_q;
  logic          done_q;
  logic          done_id_q;
  logic [W-1:0]  sum_q;
  logic          c_out_q;
  logic          ovf_q;

  logic          any_req;
  logic          pick;
  logic          pick_sub;
  logic [W-1:0]  pick_b;
  logic [3:0]    nib_s;
  logic          nib_c4;

  // On contention the client not served last wins; last_q resets to 1 so
  // client 0 has priority right after reset.
  assign any_req  = |bus_if.req;
  assign pick     = (bus_if.req[0] & bus_if.req[1]) ? ~last_q : bus_if.req[1];
  assign pick_sub = pick ? bus_if.sub_1 : bus_if.sub_0;
  assign pick_b   = pick ? bus_if.b_1 : bus_if.b_0;

  always_comb begin
    bus_if.gnt = 2'b00;
    if (rst_n && (state_q == ST_IDLE) && any_req) begin
      bus_if.gnt = pick ? 2'b10 : 2'b01;
    end
  end

  // Operands shift right each RUN cycle, so the active nibble is always [3:0]
  // and on the last cycle bit 3 holds the operand MSBs for overflow.
  bit_4_carry_lookahead u_cla (
    .a_i   (a_q[NIB_W-1:0]),
    .b_i   (b_q[NIB_W-1:0]),
    .c_0_i (carry_q),
    .s_o   (nib_s),
    .c_4_o (nib_c4)
  );

  // Result nibbles enter at the top; after NIBBLES shifts nibble 0 is at the bottom.
  assign res_d = W'({nib_s, res_q} >> NIB_W);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      carry_q   <= 1'b0;
      nib_q     <= '0;
      id_q      <= 1'b0;
      last_q    <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
      sum_q     <= '0;
      c_out_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (any_req) begin
            a_q     <= pick ? bus_if.a_1 : bus_if.a_0;
            b_q     <= pick_sub ? ~pick_b : pick_b;
            carry_q <= pick_sub;
            id_q    <= pick;
            last_q  <= pick;
            nib_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          a_q     <= a_q >> NIB_W;
          b_q     <= b_q >> NIB_W;
          res_q   <= res_d;
          carry_q <= nib_c4;
          nib_q   <= nib_q + CW'(1);
          if (nib_q == LAST_NIB) begin
            nib_q     <= '0;
            state_q   <= ST_DONE;
            done_q    <= 1'b1;
            sum_q     <= res_d;
            c_out_q   <= nib_c4;
            ovf_q     <= (a_q[NIB_W-1] == b_q[NIB_W-1]) && (nib_s[3] != a_q[NIB_W-1]);
            done_id_q <= id_q;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus_if.busy    = busy_q;
  assign bus_if.done    = done_q;
  assign bus_if.done_id = done_id_q;
  assign bus_if.sum     = sum_q;
  assign bus_if.c_out   = c_out_q;
  assign bus_if.ovf     = ovf_q;
endmodule

// File: tb/tb_shared_cla_sequencer.sv
module tb_shared_cla_sequencer;

  typedef struct {
    logic        client;
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic [15:0] sum;
    logic        c_out;
    logic        ovf;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  shared_cla_sequencer_if #(.NIBBLES(4)) bus ();

  shared_cla_sequencer #(.NIBBLES(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // One full transaction from a single client; called at a negedge.
  task automatic run_op(input vec_t v);
    int  cyc;
    logic [1:0] exp_g;
    exp_g = v.client ? 2'b10 : 2'b01;
    if (v.client) begin
      bus.a_1 = v.a; bus.b_1 = v.b; bus.sub_1 = v.sub;
    end else begin
      bus.a_0 = v.a; bus.b_0 = v.b; bus.sub_0 = v.sub;
    end
    bus.req = exp_g;
    #1;
    chk("gnt", 32'(bus.gnt), 32'(exp_g));
    cyc = 0;
    while (!bus.done && cyc < 12) begin
      @(negedge clk);
      #1;
      cyc++;
      if (cyc == 1) begin
        bus.req = 2'b00;
        chk("busy_run", 32'(bus.busy), 32'd1);
        chk("gnt_busy", 32'(bus.gnt), 32'd0);
      end
    end
    chk("latency", 32'(cyc), 32'd5);
    chk("sum", 32'(bus.sum), 32'(v.sum));
    chk("c_out", 32'(bus.c_out), 32'(v.c_out));
    chk("ovf", 32'(bus.ovf), 32'(v.ovf));
    chk("done_id", 32'(bus.done_id), 32'(v.client));
    $display("op client=%0d a=%04h b=%04h sub=%0d -> sum=%04h c=%0d ovf=%0d cyc=%0d",
             v.client, v.a, v.b, v.sub, bus.sum, bus.c_out, bus.ovf, cyc);
    @(negedge clk);
    #1;
    chk("done_pulse", 32'(bus.done), 32'd0);
    chk("busy_end", 32'(bus.busy), 32'd0);
    chk("sum_hold", 32'(bus.sum), 32'(v.sum));
  endtask

  vec_t vecs [5];

  initial begin
    int   cyc;
    int   w;
    logic seen;
    logic [1:0] exp_g;
    logic [15:0] rr_sum;

    n_checks = 0;
    n_pass   = 0;
    vecs[0] = '{1'b0, 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[4] = '{1'b0, 16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0};

    rst_n = 1'b0;
    bus.req = 2'b01;
    bus.a_0 = 16'h0; bus.b_0 = 16'h0; bus.sub_0 = 1'b0;
    bus.a_1 = 16'h0; bus.b_1 = 16'h0; bus.sub_1 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_gnt", 32'(bus.gnt), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_done_id", 32'(bus.done_id), 32'd0);
    chk("rst_sum", 32'(bus.sum), 32'd0);
    chk("rst_c_out", 32'(bus.c_out), 32'd0);
    chk("rst_ovf", 32'(bus.ovf), 32'd0);
    $display("reset state checked");
    bus.req = 2'b00;
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      run_op(vecs[i]);
    end

    // Round robin with both clients requesting continuously from reset release.
    rst_n = 1'b0;
    bus.a_0 = 16'h0001; bus.b_0 = 16'h0002; bus.sub_0 = 1'b0;
    bus.a_1 = 16'h0010; bus.b_1 = 16'h0020; bus.sub_1 = 1'b0;
    bus.req = 2'b11;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      exp_g  = (k % 2 == 1) ? 2'b10 : 2'b01;
      rr_sum = (k % 2 == 1) ? 16'h0030 : 16'h0003;
      w = 0;
      while (bus.gnt == 2'b00 && w < 10) begin
        @(negedge clk);
        #1;
        w++;
      end
      chk("rr_gnt_wait", 32'(w), 32'd0);
      chk("rr_gnt", 32'(bus.gnt), 32'(exp_g));
      cyc  = 0;
      seen = 1'b0;
      while (!bus.done && cyc < 12) begin
        @(negedge clk);
        #1;
        cyc++;
        if (bus.gnt != 2'b00) seen = 1'b1;
      end
      chk("rr_no_gnt_busy", 32'(seen), 32'd0);
      chk("rr_latency", 32'(cyc), 32'd5);
      chk("rr_done_id", 32'(bus.done_id), 32'(k % 2));
      chk("rr_sum", 32'(bus.sum), 32'(rr_sum));
      $display("rr op %0d: gnt=%b done_id=%0d sum=%04h", k, exp_g, bus.done_id, bus.sum);
      @(negedge clk);
      #1;
    end
    bus.req = 2'b00;
    @(negedge clk);
    @(negedge clk);

    // Reset during the third RUN cycle aborts the operation.
    bus.a_1 = 16'h1111; bus.b_1 = 16'h2222; bus.sub_1 = 1'b0;
    bus.req = 2'b10;
    #1;
    chk("ab_gnt", 32'(bus.gnt), 32'd2);
    seen = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      #1;
      if (bus.done) seen = 1'b1;
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ab_busy", 32'(bus.busy), 32'd0);
    chk("ab_done", 32'(bus.done), 32'd0);
    chk("ab_sum", 32'(bus.sum), 32'd0);
    chk("ab_regnt", 32'(bus.gnt), 32'd2);
    cyc = 0;
    while (!bus.done && cyc < 12) begin
      @(negedge clk);
      #1;
      cyc++;
      if (cyc == 1) bus.req = 2'b00;
    end
    chk("ab_no_early_done", 32'(seen), 32'd0);
    chk("ab_latency", 32'(cyc), 32'd5);
    chk("ab_sum_after", 32'(bus.sum), 32'h3333);
    chk("ab_done_id", 32'(bus.done_id), 32'd1);
    $display("abort test: regrant latency=%0d sum=%04h", cyc, bus.sum);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/shared_cla_sequencer.md
SHARED_CLA_SEQUENCER -- requirements
Module: shared_cla_sequencer

Interface
REQ-001 Parameter NIBBLES, default 4, number of 4-bit digits per operand; operand width W = 4*NIBBLES.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  reset; synchronous and active-low.
REQ-004 req  input  2  per-client request, level, bit i = client i; held until granted.
REQ-005 a_0, b_0  input  W each  client 0 operands.
REQ-006 sub_0  input  1  client 0 op: 0 = a+b, 1 = a-b.
REQ-007 a_1, b_1, sub_1  input  W, W, 1  client 1 operands and op.
REQ-008 gnt  output  2  one-hot acceptance, high for exactly the cycle its operands are captured.
REQ-009 busy  output  1  high from the cycle after gnt until done inclusive.
REQ-010 done  output  1  one-cycle result-valid pulse.
REQ-011 done_id  output  1  client index of the current result.
REQ-012 sum  output  W  result, two's-complement modulo 2^W.
REQ-013 c_out  output  1  carry out of MSB; for subtract, 1 = no borrow.
REQ-014 ovf  output  1  signed overflow of the operation.

Function
REQ-015 FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-016 IDLE: if any req bit set, gnt SHALL assert combinationally for one client and the operands, op and client id SHALL be captured at that clock edge; next state RUN.
REQ-017 Arbitration round-robin: single request wins; on simultaneous requests the client not served last wins; after reset client 0 has priority.
REQ-018 Capture for subtract stores ~b and sets initial carry to 1; for add stores b, carry 0.
REQ-019 RUN: one nibble per cycle, LSB nibble first, through a single 4-bit carry-lookahead adder; carry register chains nibble k's carry out to nibble k+1's carry in.
REQ-020 RUN lasts exactly NIBBLES cycles, then DONE.
REQ-021 DONE: done=1 for one cycle, then IDLE; done asserts NIBBLES+1 cycles after the gnt cycle (5 cycles for default).
REQ-022 Throughput: next gnt no earlier than the cycle after done; requests during RUN/DONE are not granted and not lost.
REQ-023 sum, c_out, ovf, done_id SHALL stay stable from done until the next done.
REQ-024 ovf = 1 iff the MSBs of a and the effective b (b, or ~b for subtract) are equal and the sum MSB differs from them.
REQ-025 gnt SHALL never assert outside IDLE; at most one gnt bit high per cycle.

Reset
REQ-026 rst_n low at a clock edge SHALL force IDLE, abort any operation in progress and clear the carry register and nibble counter.
REQ-027 Reset values: gnt=0, busy=0, done=0, done_id=0, sum=0, c_out=0, ovf=0; round-robin pointer favours client 0.
REQ-028 An aborted operation SHALL produce no done; a still-held req is granted in the first IDLE cycle after rst_n returns high.

Structure
REQ-029 Shared package holds the FSM state enumeration and the nibble-width constant (4).
REQ-030 Exactly one sub-module instance: bit_4_carry_lookahead (4-bit a, b, c_0 in; 4-bit s, c_4 out), shared by both clients.
REQ-031 Nibble counter width is clog2(NIBBLES); sum is assembled by shifting or indexed nibble writes, selectable at implementation.

Verification
REQ-032 Client 0: a_0=0x1234, b_0=0x0FFF, sub_0=0 -> gnt=01, done 5 cycles later, sum=0x2233, c_out=0, ovf=0, done_id=0.
REQ-033 Client 1: a_1=0xFFFF, b_1=0x0001, add -> sum=0x0000, c_out=1, ovf=0; then a_1=0x7FFF, b_1=0x0001 -> sum=0x8000, c_out=0, ovf=1.
REQ-034 Client 0: a_0=0x8000, b_0=0x0001, sub_0=1 -> sum=0x7FFF, c_out=1, ovf=1; a_0=0x0000, b_0=0x0001, sub -> sum=0xFFFF, c_out=0, ovf=0.
REQ-035 req=11 held continuously from reset release -> grants alternate 01, 10, 01, ...; done_id sequence 0,1,0; no gnt during busy.
REQ-036 rst_n low for one cycle during the third RUN cycle -> next cycle busy=0, done=0, sum=0; no done for the aborted op; held req=10 is granted in the first cycle after rst_n returns high.
